// File: rtl/hist_accum_ctrl.sv
// ---------------------------------------------------------------------------
// hist_accum_ctrl
//
// Purpose
//   Controls a 64-word x 64-bit external register file that holds a 256-bin
//   histogram of 8-bit pixels. Each word packs four 16-bit bin counters:
//   bin b lives in word b[7:2], lane b[1:0], bits [16*lane+15:16*lane].
//   The controller can clear the whole histogram, or take in a vector of
//   eight pixels and add each pixel to its bin, one pixel per cycle.
//   Counters saturate at 0xFFFF.
//
// Ports
//   clk          in   1  system clock, rising-edge
//   rst          in   1  asynchronous active-high reset
//   clr_start    in   1  one-cycle request to clear the histogram
//   pix_valid    in   1  pixel vector offered on pix_data
//   pix_ready    out  1  pixel vector accepted this cycle (with pix_valid)
//   pix_data     in  64  eight pixels, pixel i at bits [8i+7:8i]
//   busy         out  1  controller is clearing or accumulating
//   sat_flag     out  1  sticky: some bin counter hit 0xFFFF on an update
//   pix_count    out 32  pixels accumulated since the last clear (wraps)
//   rf_we        out  1  register-file write enable
//   rf_get8      out  1  register-file GET8 select, always 0
//   rf_a1        out  6  register-file read address
//   rf_a2        out  6  register-file write address
//   rf_wd        out 64  register-file write data
//   rf_rd        in  64  register-file read data (combinational from rf_a1)
//   dbg_state_o  out  2  current FSM state (0 IDLE, 1 CLEAR, 2 ACCUM)
//
// Handshake
//   The pixel vector transfers on a rising edge where pix_valid and
//   pix_ready are both high. pix_ready is combinational: high only in IDLE
//   while clr_start is low, so a simultaneous clear request wins and the
//   vector stays with the producer. The producer must hold pix_data stable
//   while pix_valid is high and not yet accepted.
// ---------------------------------------------------------------------------
module hist_accum_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [63:0] pix_data,
    output logic        busy,
    output logic        sat_flag,
    output logic [31:0] pix_count,
    output logic        rf_we,
    output logic        rf_get8,
    output logic [5:0]  rf_a1,
    output logic [5:0]  rf_a2,
    output logic [63:0] rf_wd,
    input  logic [63:0] rf_rd,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  clr_addr_q, clr_addr_d;
    logic [2:0]  lane_q, lane_d;
    logic [63:0] pix_q, pix_d;
    logic [31:0] pix_count_q, pix_count_d;
    logic        sat_q, sat_d;

    // -----------------------------------------------------------------------
    // Datapath for the pixel currently being accumulated
    // -----------------------------------------------------------------------
    logic [7:0]  cur_pixel;
    logic [5:0]  bin_word;
    logic [1:0]  bin_lane;
    logic [15:0] lane_val;
    logic        lane_sat;
    logic [15:0] lane_inc;
    logic [63:0] accum_wd;

    assign cur_pixel = pix_q[{lane_q, 3'b000} +: 8];
    assign bin_word  = cur_pixel[7:2];
    assign bin_lane  = cur_pixel[1:0];
    assign lane_val  = rf_rd[{bin_lane, 4'b0000} +: 16];
    assign lane_sat  = (lane_val == 16'hFFFF);
    // A full counter is held rather than wrapped.
    assign lane_inc  = lane_sat ? lane_val : (lane_val + 16'd1);

    // Read-modify-write word: only the selected lane changes. Same-bin
    // back-to-back pixels work because the register file makes the
    // previous cycle's write visible on rf_rd in the next cycle.
    always_comb begin
        accum_wd = rf_rd;
        accum_wd[{bin_lane, 4'b0000} +: 16] = lane_inc;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            clr_addr_q  <= 6'd0;
            lane_q      <= 3'd0;
            pix_q       <= 64'd0;
            pix_count_q <= 32'd0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            lane_q      <= lane_d;
            pix_q       <= pix_d;
            pix_count_q <= pix_count_d;
            sat_q       <= sat_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        lane_d      = lane_q;
        pix_d       = pix_q;
        pix_count_d = pix_count_q;
        sat_d       = sat_q;
        pix_ready   = 1'b0;
        busy        = 1'b0;
        rf_we       = 1'b0;
        rf_a1       = 6'd0;
        rf_a2       = 6'd0;
        rf_wd       = 64'd0;

        case (state_q)
            ST_IDLE: begin
                pix_ready = ~clr_start;
                if (clr_start) begin
                    // Clear wins over a simultaneously offered vector.
                    state_d     = ST_CLEAR;
                    clr_addr_d  = 6'd0;
                    pix_count_d = 32'd0;
                    sat_d       = 1'b0;
                end else if (pix_valid) begin
                    state_d = ST_ACCUM;
                    pix_d   = pix_data;
                    lane_d  = 3'd0;
                end
            end

            ST_CLEAR: begin
                // clr_start is deliberately not looked at here.
                busy  = 1'b1;
                rf_we = 1'b1;
                rf_a2 = clr_addr_q;
                rf_wd = 64'd0;
                if (clr_addr_q == 6'd63) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = 6'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 6'd1;
                end
            end

            ST_ACCUM: begin
                busy        = 1'b1;
                rf_we       = 1'b1;
                rf_a1       = bin_word;
                rf_a2       = bin_word;
                rf_wd       = accum_wd;
                pix_count_d = pix_count_q + 32'd1;
                if (lane_sat) begin
                    sat_d = 1'b1;
                end
                if (lane_q == 3'd7) begin
                    state_d = ST_IDLE;
                    lane_d  = 3'd0;
                end else begin
                    lane_d = lane_q + 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sat_flag    = sat_q;
    assign pix_count   = pix_count_q;
    assign rf_get8     = 1'b0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hist_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hist_accum_ctrl
//
// Directed bench for hist_accum_ctrl. Provides a 64 x 64-bit register file
// model (combinational read, clocked write, plus a side port the bench uses
// to preload words), drives a linear sequence of directed steps and checks
// hand-computed values with immediate assertions.
// ---------------------------------------------------------------------------
module tb_hist_accum_ctrl;

    logic        clk;
    logic        rst;
    logic        clr_start;
    logic        pix_valid;
    logic        pix_ready;
    logic [63:0] pix_data;
    logic        busy;
    logic        sat_flag;
    logic [31:0] pix_count;
    logic        rf_we;
    logic        rf_get8;
    logic [5:0]  rf_a1;
    logic [5:0]  rf_a2;
    logic [63:0] rf_wd;
    logic [63:0] rf_rd;
    logic [1:0]  dbg_state;

    // register file model
    logic [63:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [63:0] pl_data;

    int total;
    int bad;

    logic [63:0] wd_seq [4];

    hist_accum_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clr_start   (clr_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .busy        (busy),
        .sat_flag    (sat_flag),
        .pix_count   (pix_count),
        .rf_we       (rf_we),
        .rf_get8     (rf_get8),
        .rf_a1       (rf_a1),
        .rf_a2       (rf_a2),
        .rf_wd       (rf_wd),
        .rf_rd       (rf_rd),
        .dbg_state_o (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rf_we) begin
            mem[rf_a2] <= rf_wd;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    assign rf_rd = mem[rf_a1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept_vec(input logic [63:0] data);
        pix_data  = data;
        pix_valid = 1'b1;
        #1;
        check("accept_ready", 96'(pix_ready), 96'(1'b1));
        tick();
        pix_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        clr_start = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 64'd0;
        pl_en     = 1'b0;
        pl_addr   = 6'd0;
        pl_data   = 64'd0;
        wd_seq[0] = 64'h0000_0000_0000_0001;
        wd_seq[1] = 64'h0000_0000_0001_0001;
        wd_seq[2] = 64'h0000_0001_0001_0001;
        wd_seq[3] = 64'h0001_0001_0001_0001;

        // ---- reset: fill register file with garbage meanwhile ----
        for (int a = 0; a < 64; a++) begin
            pl_en   = 1'b1;
            pl_addr = 6'(a);
            pl_data = 64'hDEAD_BEEF_0000_0000 | 64'(a);
            tick();
        end
        pl_en = 1'b0;
        check("rst_ctrl", {90'd0, busy, rf_we, rf_get8, sat_flag, dbg_state}, 96'd0);
        check("rst_addr", {84'd0, rf_a1, rf_a2}, 96'd0);
        check("rst_wd", 96'(rf_wd), 96'd0);
        check("rst_count", 96'(pix_count), 96'd0);
        rst = 1'b0;
        tick();
        check("rst_ready", 96'(pix_ready), 96'(1'b1));

        // ---- clear ----
        clr_start = 1'b1;
        #1;
        check("clr_req_ready", 96'(pix_ready), 96'd0);
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check("clr_cycle", {busy, rf_we, rf_a2, rf_wd}, {1'b1, 1'b1, 6'(i), 64'd0});
            tick();
        end
        check("clr_done", {92'd0, dbg_state, busy, pix_ready}, {92'd0, 2'd0, 1'b0, 1'b1});
        check("clr_mem0", 96'(mem[0]), 96'd0);
        check("clr_mem63", 96'(mem[63]), 96'd0);

        // ---- accumulate pixels 0..7 ----
        accept_vec(64'h0706_0504_0302_0100);
        for (int k = 0; k < 8; k++) begin
            check("acc_ctrl", {busy, pix_ready, rf_we, rf_a1, rf_a2},
                  {1'b1, 1'b0, 1'b1, 6'(k / 4), 6'(k / 4)});
            check("acc_wd", 96'(rf_wd), 96'(wd_seq[k % 4]));
            tick();
        end
        check("acc_idle", 96'(dbg_state), 96'd0);
        check("acc_count", 96'(pix_count), 96'd8);
        check("acc_word0", 96'(mem[0]), 96'h0001_0001_0001_0001);
        check("acc_word1", 96'(mem[1]), 96'h0001_0001_0001_0001);
        check("acc_sat", 96'(sat_flag), 96'd0);

        // ---- same bin, accepted back-to-back; clr_start in ACCUM ignored ----
        accept_vec(64'h2A2A_2A2A_2A2A_2A2A);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) clr_start = 1'b1;
            if (k == 4) begin
                clr_start = 1'b0;
                check("same_clr_ignored", 96'(dbg_state), 96'd2);
            end
            check("same_addr", {84'd0, rf_a1, rf_a2}, {84'd0, 6'd10, 6'd10});
            check("same_wd", 96'(rf_wd), 96'(64'(k + 1) << 32));
            tick();
        end
        check("same_word10", 96'(mem[10]), 96'h0000_0008_0000_0000);
        check("same_count", 96'(pix_count), 96'd16);
        check("same_idle", {94'd0, busy, pix_ready}, {94'd0, 1'b0, 1'b1});

        // ---- saturation ----
        pl_en   = 1'b1;
        pl_addr = 6'd0;
        pl_data = 64'h0001_0001_0001_FFFF;
        tick();
        pl_en = 1'b0;
        accept_vec(64'h0);
        for (int k = 0; k < 8; k++) begin
            check("sat_wd", 96'(rf_wd), 96'h0001_0001_0001_FFFF);
            check("sat_flag_step", 96'(sat_flag), 96'(k >= 1));
            tick();
        end
        check("sat_flag_end", 96'(sat_flag), 96'd1);
        check("sat_count", 96'(pix_count), 96'd24);
        check("sat_word0", 96'(mem[0]), 96'h0001_0001_0001_FFFF);

        // ---- clear wins over vector; clr_start in CLEAR ignored ----
        pix_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        pix_valid = 1'b1;
        clr_start = 1'b1;
        #1;
        check("conf_ready", 96'(pix_ready), 96'd0);
        tick();
        clr_start = 1'b0;
        pix_valid = 1'b0;
        check("conf_state", 96'(dbg_state), 96'd1);
        check("conf_zeroed", {63'd0, sat_flag, pix_count}, 96'd0);
        for (int i = 0; i < 64; i++) begin
            clr_start = (i == 10);
            #1;
            check("conf_clr_addr", {89'd0, rf_we, rf_a2}, {89'd0, 1'b1, 6'(i)});
            tick();
        end
        clr_start = 1'b0;
        check("conf_done", {93'd0, dbg_state, pix_ready}, {93'd0, 2'd0, 1'b1});
        tick();
        check("conf_not_consumed", {64'd0, pix_count}, 96'd0);
        check("conf_mem63", 96'(mem[63]), 96'd0);

        // ---- reset during ACCUM ----
        accept_vec(64'h0706_0504_0302_0100);
        tick();
        tick();
        tick();
        check("abort_count_pre", 96'(pix_count), 96'd3);
        rst = 1'b1;
        #1;
        check("abort_ctrl", {92'd0, rf_we, busy, dbg_state}, 96'd0);
        check("abort_outs", {64'd0, pix_count}, 96'd0);
        check("abort_bus", {rf_a1, rf_a2, rf_wd}, 76'd0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_word0", 96'(mem[0]), 96'h0000_0001_0001_0001);
        check("abort_word1", 96'(mem[1]), 96'd0);
        check("abort_ready", 96'(pix_ready), 96'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
